// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_ctrl
// Brief    : Multi-digit scan controller feeding a single 4-bit, MODE-qualified
//            7-segment decoder. Time-multiplexes a held value one nibble per
//            slot, drives active-low anodes with a blanking gap at the start
//            of every slot, and commits newly loaded values only at the frame
//            boundary so a frame never mixes old and new digits.
//            Optional macro LZ_BLANK_EN enables leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl #(
    parameter  int DIGITS       = 4,
    parameter  int PRESCALE     = 50000,
    parameter  int BLANK_CYCLES = 16,
    localparam int IW           = $clog2(DIGITS),
    localparam int CW           = $clog2(PRESCALE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic                  i_mode_in,
    output logic [3:0]            o_data,
    output logic                  o_mode,
    output logic [DIGITS-1:0]     o_an,
    output logic [IW-1:0]         o_dig_idx,
    output logic                  o_pending
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0]    c_st_blank   = 1'b0;
    localparam logic [0:0]    c_st_show    = 1'b1;
    localparam logic [CW-1:0] c_cnt_last   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] c_cnt_one    = CW'(1);
    localparam logic [IW-1:0] c_idx_last   = IW'(DIGITS - 1);
    localparam logic [IW-1:0] c_idx_one    = IW'(1);

    // ------------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       w_idx_nxt;

    // ------------------------------------------------------------------------
    // Value path: staged (written by LOAD) and shadow (what is displayed)
    // ------------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_staged;
    logic                r_staged_mode;
    logic [4*DIGITS-1:0] r_shadow;
    logic                r_shadow_mode;
    logic                r_pending;
    logic [4*DIGITS-1:0] w_shadow_nxt;
    logic                w_shadow_mode_nxt;

    // ------------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------------
    logic [DIGITS-1:0]   w_digit_on;
    logic [DIGITS-1:0]   w_an_nxt;
    logic [3:0]          w_data_nxt;
    logic                w_mode_nxt;
    logic [DIGITS-1:0]   r_an;
    logic [3:0]          r_data;
    logic                r_mode;

    logic                w_blank_end;
    logic                w_slot_end;
    logic                w_commit;

    // The frame boundary is the last cycle of the last digit's slot.
    assign w_blank_end = (r_cnt == c_blank_last);
    assign w_slot_end  = (r_cnt == c_cnt_last);
    assign w_commit    = w_slot_end && (r_idx == c_idx_last);

    // State register: FSM state, slot counter and current digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_blank;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: BLANK for the first BLANK_CYCLES of a slot, SHOW for
    // the remainder; the slot counter spans the whole slot.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        w_idx_nxt   = r_idx;
        case (r_state)
            c_st_blank: begin
                if (w_blank_end) begin
                    w_state_nxt = c_st_show;
                end
            end
            c_st_show: begin
                if (w_slot_end) begin
                    w_state_nxt = c_st_blank;
                    w_cnt_nxt   = '0;
                    if (r_idx == c_idx_last) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_idx_nxt = r_idx + c_idx_one;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_blank;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Shadow update at the commit edge: a LOAD on that very edge bypasses the
    // staged copy, otherwise a pending staged value is taken over.
    always_comb begin
        w_shadow_nxt      = r_shadow;
        w_shadow_mode_nxt = r_shadow_mode;
        if (w_commit) begin
            if (i_load) begin
                w_shadow_nxt      = i_value;
                w_shadow_mode_nxt = i_mode_in;
            end else if (r_pending) begin
                w_shadow_nxt      = r_staged;
                w_shadow_mode_nxt = r_staged_mode;
            end
        end
    end

    // Value registers: LOAD stages (last one wins) except on the commit edge,
    // where the pending flag is always cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_staged      <= '0;
            r_staged_mode <= 1'b0;
            r_shadow      <= '0;
            r_shadow_mode <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            r_shadow      <= w_shadow_nxt;
            r_shadow_mode <= w_shadow_mode_nxt;
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (i_load) begin
                r_staged      <= i_value;
                r_staged_mode <= i_mode_in;
                r_pending     <= 1'b1;
            end
        end
    end

`ifdef LZ_BLANK_EN
    // A digit above 0 is suppressed when it and every more significant nibble
    // are zero; digit 0 always lights so a zero value still shows "0".
    assign w_digit_on[0] = 1'b1;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
        assign w_digit_on[gi] = |w_shadow_nxt[4*DIGITS-1:4*gi];
    end
`else
    // Every digit is lit during its SHOW phase.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_no_lz
        assign w_digit_on[gi] = 1'b1;
    end
`endif

    // Output logic: computed from next state/index/shadow so the registered
    // outputs change on the very edge that enters the new state or slot.
    always_comb begin
        w_an_nxt   = '1;
        w_data_nxt = 4'h0;
        w_mode_nxt = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_data_nxt = w_shadow_nxt[4*i +: 4];
                if (w_state_nxt == c_st_show) begin
                    w_an_nxt[i] = ~w_digit_on[i];
                end
            end
        end
        // Sign indication is confined to the most significant digit.
        if (w_idx_nxt == c_idx_last) begin
            w_mode_nxt = w_shadow_mode_nxt;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an   <= '1;
            r_data <= 4'h0;
            r_mode <= 1'b0;
        end else begin
            r_an   <= w_an_nxt;
            r_data <= w_data_nxt;
            r_mode <= w_mode_nxt;
        end
    end

    assign o_an      = r_an;
    assign o_data    = r_data;
    assign o_mode    = r_mode;
    assign o_dig_idx = r_idx;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Brief    : Self-checking bench for disp_scan_ctrl (DIGITS=4, PRESCALE=8,
//            BLANK_CYCLES=2). Expected per-slot outputs are queued whenever a
//            frame's value becomes known and popped as the DUT scans.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        load    = 1'b0;
    logic        mode_in = 1'b0;
    logic [15:0] value   = 16'h0;
    logic [3:0]  o_data;
    logic        o_mode;
    logic [3:0]  o_an;
    logic [1:0]  o_dig_idx;
    logic        o_pending;

    disp_scan_ctrl #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .i_load    (load),
        .i_value   (value),
        .i_mode_in (mode_in),
        .o_data    (o_data),
        .o_mode    (o_mode),
        .o_an      (o_an),
        .o_dig_idx (o_dig_idx),
        .o_pending (o_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] data;
        logic       mode;
        logic [3:0] an;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_shadow      = 16'h0;
    logic        m_mode        = 1'b0;
    logic [15:0] m_staged      = 16'h0;
    logic        m_staged_mode = 1'b0;
    logic        m_pend        = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected SHOW-phase anode pattern for digit i of value v.
    function automatic logic [3:0] exp_an(input int i, input logic [15:0] v);
        logic [3:0] a;
        a    = 4'hF;
        a[i] = 1'b0;
`ifdef LZ_BLANK_EN
        if (i > 0 && (v >> (4 * i)) == 16'h0) a = 4'hF;
`endif
        return a;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < DIGITS; i++) begin
            e.idx  = 2'(i);
            e.data = m_shadow[4*i +: 4];
            e.mode = (i == DIGITS - 1) ? m_mode : 1'b0;
            e.an   = exp_an(i, m_shadow);
            sbq.push_back(e);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_an",   16'(o_an),      16'hF);
        check("rst_data", 16'(o_data),    16'h0);
        check("rst_mode", 16'(o_mode),    16'h0);
        check("rst_idx",  16'(o_dig_idx), 16'h0);
        check("rst_pend", 16'(o_pending), 16'h0);
    endtask

    // Scan one slot, checking every cycle; optionally pulse LOAD at cycle
    // 'at' or RST at cycle 'rst_at' (the slot ends early on reset).
    task automatic scan_slot(input bit do_load, input int at, input logic [15:0] v,
                             input logic m, input int rst_at);
        exp_t e;
        bit   commit;
        bit   loaded;
        check("sb_avail", 16'(sbq.size() != 0), 16'h1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        for (int k = 0; k < PRESCALE; k++) begin
            check("an",   16'(o_an),      (k < BLANK) ? 16'hF : 16'(e.an));
            check("data", 16'(o_data),    16'(e.data));
            check("mode", 16'(o_mode),    16'(e.mode));
            check("idx",  16'(o_dig_idx), 16'(e.idx));
            check("pend", 16'(o_pending), 16'(m_pend));
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst      = 1'b0;
                m_shadow = 16'h0;
                m_mode   = 1'b0;
                m_staged = 16'h0;
                m_pend   = 1'b0;
                sbq.delete();
                push_frame();
                return;
            end
            commit = (k == PRESCALE - 1) && (e.idx == 2'(DIGITS - 1));
            loaded = 1'b0;
            if (do_load && k == at) begin
                load    = 1'b1;
                value   = v;
                mode_in = m;
                loaded  = 1'b1;
            end
            tick();
            load = 1'b0;
            if (commit) begin
                if (loaded) begin
                    m_shadow = v;
                    m_mode   = m;
                end else if (m_pend) begin
                    m_shadow = m_staged;
                    m_mode   = m_staged_mode;
                end
                m_pend = 1'b0;
                push_frame();
            end else if (loaded) begin
                m_staged      = v;
                m_staged_mode = m;
                m_pend        = 1'b1;
            end
        end
    endtask

    task automatic plain_slot();
        scan_slot(1'b0, 0, 16'h0, 1'b0, -1);
    endtask

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        push_frame();

        // Frame of zeros; LOAD 1A3F mid-frame.
        plain_slot();
        scan_slot(1'b1, 3, 16'h1A3F, 1'b0, -1);
        plain_slot();
        plain_slot();

        // Frame shows F,3,A,1; LOAD signed 8001.
        scan_slot(1'b1, 5, 16'h8001, 1'b1, -1);
        plain_slot();
        plain_slot();
        plain_slot();

        // Frame shows 8001 with MODE only on digit 3; two LOADs, last wins.
        scan_slot(1'b1, 2, 16'h1111, 1'b0, -1);
        plain_slot();
        scan_slot(1'b1, 6, 16'h2222, 1'b0, -1);
        plain_slot();

        // Frame shows 2222; LOAD 5555 exactly on the commit edge.
        plain_slot();
        plain_slot();
        plain_slot();
        scan_slot(1'b1, 7, 16'h5555, 1'b0, -1);

        // Frame shows 5555; LOAD 0042.
        scan_slot(1'b1, 1, 16'h0042, 1'b0, -1);
        plain_slot();
        plain_slot();
        plain_slot();

        // Frame shows 0042.
        plain_slot();
        plain_slot();
        plain_slot();
        plain_slot();

        // Stage 7777, then reset during SHOW of digit 2; staged data is lost.
        scan_slot(1'b1, 0, 16'h7777, 1'b0, -1);
        plain_slot();
        scan_slot(1'b0, 0, 16'h0, 1'b0, 4);
        check_reset_vals();

        // First frame after reset shows zero, digit 0 first.
        plain_slot();
        plain_slot();
        plain_slot();
        plain_slot();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
